// File: rtl/mixcol_serial_ctrl.sv
// mixcol_serial_ctrl: column-serial MixColumns scheduler.
// Accepts a full AES state, runs its columns one per cycle through a single
// shared GF(2^8) column mixer, writes each result back into the state buffer,
// then presents the mixed state downstream over valid/ready.
// Optional build macro MIXCOL_BYPASS_EN adds i_Bypass: a state accepted with
// i_Bypass=1 skips mixing and is presented unmodified (final AES round).
module mixcol_serial_ctrl #(
  parameter int NUM_COLS = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Valid,
  output logic                    o_Ready,
  input  logic [32*NUM_COLS-1:0]  i_Data,
`ifdef MIXCOL_BYPASS_EN
  input  logic                    i_Bypass,
`endif
  output logic                    o_Valid,
  input  logic                    i_Ready,
  output logic [32*NUM_COLS-1:0]  o_Data,
  output logic                    o_Busy
);

  localparam int            CW       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          col_q;
  logic [31:0]            buf_q [NUM_COLS];
  logic [32*NUM_COLS-1:0] out_q;
  logic [31:0]            col_mixed;
  logic [32*NUM_COLS-1:0] merged;
  logic                   bypass;
  logic                   accept;

`ifdef MIXCOL_BYPASS_EN
  assign bypass = i_Bypass;
`else
  assign bypass = 1'b0;
`endif

  // Multiply a byte by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // One MixColumns column: rows 02 03 01 01, rotated per output byte.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // The shared column mixer, fed by the column currently being processed.
  assign col_mixed = mix_column(buf_q[col_q]);
  assign accept    = i_Valid & o_Ready;
  assign o_Data    = out_q;

  // Full state as it will look after this cycle's write-back; captured into
  // the output register on the last RUN cycle.
  always_comb begin
    merged = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      merged[32*(NUM_COLS-i)-1 -: 32] = (CW'(i) == col_q) ? col_mixed : buf_q[i];
    end
  end

  // State register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    state_d = state_q;
    o_Ready = 1'b0;
    o_Valid = 1'b0;
    o_Busy  = 1'b0;
    case (state_q)
      IDLE: begin
        o_Ready = 1'b1;
        if (i_Valid) state_d = bypass ? DONE : RUN;
      end
      RUN: begin
        o_Busy = 1'b1;
        if (col_q == LAST_COL) state_d = DONE;
      end
      DONE: begin
        o_Valid = 1'b1;
        if (i_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, write one mixed column back per RUN cycle,
  // and update the output register only when a complete state is ready.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      col_q <= '0;
      out_q <= '0;
      // NOTE: the state buffer is reset on purpose: it is small, and a defined
      // all-zero value after reset keeps partial states from ever leaking out.
      for (int i = 0; i < NUM_COLS; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            col_q <= '0;
            for (int i = 0; i < NUM_COLS; i++) buf_q[i] <= i_Data[32*(NUM_COLS-i)-1 -: 32];
            if (bypass) out_q <= i_Data;
          end
        end
        RUN: begin
          buf_q[col_q] <= col_mixed;
          if (col_q == LAST_COL) begin
            col_q <= '0;
            out_q <= merged;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mixcol_serial_ctrl.sv
// Self-checking bench for mixcol_serial_ctrl (NUM_COLS=4).
// Stimulus pushes expected states into a queue; an independent monitor pops
// and compares on every output transfer. Bypass checks run when the bench is
// compiled with MIXCOL_BYPASS_EN.
module tb_mixcol_serial_ctrl;

  localparam int NUM_COLS = 4;
  localparam int W        = 32 * NUM_COLS;

  localparam logic [W-1:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [W-1:0] FIPS_EXP = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [W-1:0] V2_IN    = 128'hd4d4d4d5_2d26314c_00000000_80808080;
  localparam logic [W-1:0] V2_EXP   = 128'hd5d5d7d6_4d7ebdf8_00000000_80808080;
  localparam logic [W-1:0] X_IN     = 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c;
  localparam logic [W-1:0] X_EXP    = 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8;
  localparam logic [W-1:0] BYP_IN   = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] data_in;
  logic         bypass_in;
  logic         valid_out;
  logic         ready_in;
  logic [W-1:0] data_out;
  logic         busy;

  int           n_vec  = 0;
  int           n_miss = 0;
  logic [W-1:0] exp_q [$];
  time          acc_time;
  logic         watch_busy = 1'b0;
  logic         busy_seen  = 1'b0;

  mixcol_serial_ctrl #(.NUM_COLS(NUM_COLS)) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Valid  (valid_in),
    .o_Ready  (ready_out),
    .i_Data   (data_in),
`ifdef MIXCOL_BYPASS_EN
    .i_Bypass (bypass_in),
`endif
    .o_Valid  (valid_out),
    .i_Ready  (ready_in),
    .o_Data   (data_out),
    .o_Busy   (busy)
  );

  always #5 clk = ~clk;

  // Reference GF(2^8) multiply by shift-and-add over the bits of b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Reference MixColumns over the whole state via the circulant matrix.
  function automatic logic [W-1:0] mix_state(input logic [W-1:0] s);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   r;
    logic [W-1:0] res;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    res = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[W-1-32*c-8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        r = 8'h00;
        for (int k = 0; k < 4; k++) r = r ^ gmul(a[k], coef[(k - row + 4) % 4]);
        res[W-1-32*c-8*row -: 8] = r;
      end
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one state; returns at posedge+1 of the accept edge. The expected
  // result is queued for the monitor.
  task automatic send(input logic [W-1:0] d, input logic byp, input logic [W-1:0] exp);
    int t;
    t = 0;
    valid_in  = 1'b1;
    data_in   = d;
    bypass_in = byp;
    @(negedge clk);
    while (!ready_out && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", W'(ready_out), W'(1));
    exp_q.push_back(exp);
    @(posedge clk);
    acc_time = $time;
    #1;
    valid_in = 1'b0;
  endtask

  // Count edges after the accept edge until o_Valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_out && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Scoreboard monitor: compare on every output transfer.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_output: got %h expected no transfer", data_out);
      end else begin
        check("out_data", data_out, exp_q.pop_front());
      end
    end
    if (watch_busy && busy) busy_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n;
    time          prev_t;
    logic [W-1:0] d;

    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_in  = 1'b0;
    data_in   = '0;
    bypass_in = 1'b0;
    #1;
    check("rst_valid", W'(valid_out), W'(0));
    check("rst_ready", W'(ready_out), W'(1));
    check("rst_busy",  W'(busy),      W'(0));
    check("rst_data",  data_out,      '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // FIPS-197 vector with latency check.
    ready_in = 1'b1;
    send(FIPS_IN, 1'b0, FIPS_EXP);
    check("fips_busy", W'(busy), W'(1));
    wait_valid(n);
    check("fips_latency", W'(n), W'(4));
    @(posedge clk);
    #1;

    // Second vector, then an asynchronous reset in the middle of RUN.
    send(V2_IN, 1'b0, V2_EXP);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_valid", W'(valid_out), W'(0));
    check("midrst_ready", W'(ready_out), W'(1));
    check("midrst_busy",  W'(busy),      W'(0));
    check("midrst_data",  data_out,      '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(V2_IN, 1'b0, V2_EXP);
    wait_valid(n);
    check("v2_latency", W'(n), W'(4));
    @(posedge clk);
    #1;

    // Backpressure in DONE with new input offered during RUN and DONE.
    ready_in = 1'b0;
    send(V2_IN, 1'b0, V2_EXP);
    valid_in = 1'b1;
    data_in  = X_IN;
    check("run_ready", W'(ready_out), W'(0));
    wait_valid(n);
    check("bp_latency", W'(n), W'(4));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", W'(valid_out), W'(1));
      check("bp_data",  data_out,      V2_EXP);
      check("bp_ready", W'(ready_out), W'(0));
    end
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    send(X_IN, 1'b0, X_EXP);
    wait_valid(n);
    check("x_latency", W'(n), W'(4));
    @(posedge clk);
    #1;

`ifdef MIXCOL_BYPASS_EN
    // Bypass: unmodified data, valid right after the accept edge, never busy.
    busy_seen  = 1'b0;
    watch_busy = 1'b1;
    send(BYP_IN, 1'b1, BYP_IN);
    wait_valid(n);
    check("byp_latency", W'(n), W'(0));
    repeat (3) @(posedge clk);
    #1;
    watch_busy = 1'b0;
    check("byp_busy", W'(busy_seen), W'(0));
    send(BYP_IN, 1'b0, mix_state(BYP_IN));
    wait_valid(n);
    check("nobyp_latency", W'(n), W'(4));
    @(posedge clk);
    #1;
`endif

    // Back-to-back random states with i_Valid/i_Ready held high.
    prev_t = 0;
    for (int k = 0; k < 1000; k++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(d, 1'b0, mix_state(d));
      if (k > 0) check("b2b_interval", W'((acc_time - prev_t) / 10), W'(6));
      prev_t = acc_time;
    end
    valid_in = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
